ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_loader.sv | 230 +++++++++++++++++++++++
 tb/tb_ccff_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_loader.sv
// ccff_loader: streams bitstream words MSB-first into a configuration chain.
// Readback by chain rotation is compiled in only with CCFF_READBACK_EN.
module ccff_loader #(
   parameter int unsigned CHAIN_LEN = 36,
   parameter int unsigned WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              prog_clk_en,
   output logic              busy,
   output logic              done,
   input  logic              rb_req,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid
);

   localparam int unsigned NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int unsigned LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
   localparam int unsigned BIT_W     = $clog2(WORD_W + 1);
   localparam int unsigned WRD_W     = $clog2(NWORDS + 1);
   localparam int unsigned SH_W      = $clog2(CHAIN_LEN + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
`ifdef CCFF_READBACK_EN
      RB   = 2'd3,
`endif
      DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [BIT_W-1:0]  bits_q, bits_d;
   logic [WRD_W-1:0]  words_q, words_d;
   logic [SH_W-1:0]   shifts_q, shifts_d;
   logic              head_q, head_d;
   logic              en_q, en_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              accept;
   logic [WORD_W-1:0] src;
   logic [BIT_W-1:0]  cnt;
   logic [SH_W-1:0]   shifts_nx;
   logic [BIT_W:0]    left;

   assign accept = ready_q & bs_valid;

`ifdef CCFF_READBACK_EN
   logic [SH_W-1:0]   rb_cnt_q, rb_cnt_d;
   logic [WORD_W-1:0] rb_acc_q, rb_acc_d;
   logic [BIT_W-1:0]  rb_nb_q, rb_nb_d;
   logic [WORD_W-1:0] rb_data_q, rb_data_d;
   logic              rb_valid_q, rb_valid_d;
   logic [WORD_W-1:0] acc_nx;
   logic [BIT_W-1:0]  nb_nx;
   logic              rb_last;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      bits_d    = bits_q;
      words_d   = words_q;
      shifts_d  = shifts_q;
      head_d    = head_q;
      en_d      = 1'b0;
      done_d    = 1'b0;
      src       = '0;
      cnt       = '0;
      shifts_nx = shifts_q;
`ifdef CCFF_READBACK_EN
      rb_cnt_d   = rb_cnt_q;
      rb_acc_d   = rb_acc_q;
      rb_nb_d    = rb_nb_q;
      rb_data_d  = rb_data_q;
      rb_valid_d = 1'b0;
      acc_nx     = {rb_acc_q[WORD_W-2:0], ccff_tail};
      nb_nx      = rb_nb_q + BIT_W'(1);
      rb_last    = (rb_cnt_q == SH_W'(CHAIN_LEN - 1));
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = LOAD;
               sreg_d   = '0;
               bits_d   = '0;
               words_d  = '0;
               shifts_d = '0;
            end
`ifdef CCFF_READBACK_EN
            else if (rb_req) begin
               state_d  = RB;
               en_d     = 1'b1;
               rb_cnt_d = '0;
               rb_acc_d = '0;
               rb_nb_d  = '0;
            end
`endif
         end
         LOAD: begin
            shifts_nx = shifts_q + SH_W'(en_q);
            shifts_d  = shifts_nx;
            if (shifts_nx == SH_W'(CHAIN_LEN)) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               // The bit scheduled here is presented on head next cycle
               src = accept ? bs_data : sreg_q;
               if (accept)
                  cnt = (words_q == WRD_W'(NWORDS - 1)) ? BIT_W'(LAST_BITS) : BIT_W'(WORD_W);
               else
                  cnt = bits_q;
               if (accept) words_d = words_q + WRD_W'(1);
               if (cnt != '0) begin
                  head_d = src[WORD_W-1];
                  en_d   = 1'b1;
                  sreg_d = src << 1;
                  bits_d = cnt - BIT_W'(1);
               end else begin
                  sreg_d = src;
                  bits_d = '0;
               end
            end
         end
         DONE: state_d = IDLE;
`ifdef CCFF_READBACK_EN
         RB: begin
            rb_cnt_d = rb_cnt_q + SH_W'(1);
            // Close a word when full or at the chain end, left-aligned
            if (nb_nx == BIT_W'(WORD_W) || rb_last) begin
               rb_valid_d = 1'b1;
               rb_data_d  = acc_nx << (BIT_W'(WORD_W) - nb_nx);
               rb_acc_d   = '0;
               rb_nb_d    = '0;
            end else begin
               rb_acc_d = acc_nx;
               rb_nb_d  = nb_nx;
            end
            if (rb_last) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               en_d = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      // The bit on head counts as one still left in the register
      left    = {1'b0, bits_d} + (BIT_W + 1)'(en_d);
      ready_d = (state_d == LOAD) && (left < (BIT_W + 1)'(2)) &&
                (words_d < WRD_W'(NWORDS));
`ifdef CCFF_READBACK_EN
      busy_d  = (state_d == LOAD) || (state_d == RB);
`else
      busy_d  = (state_d == LOAD);
`endif
   end

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state_q  <= IDLE;
         sreg_q   <= '0;
         bits_q   <= '0;
         words_q  <= '0;
         shifts_q <= '0;
         head_q   <= 1'b0;
         en_q     <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sreg_q   <= sreg_d;
         bits_q   <= bits_d;
         words_q  <= words_d;
         shifts_q <= shifts_d;
         head_q   <= head_d;
         en_q     <= en_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bs_ready    = ready_q;
   assign prog_clk_en = en_q;
   assign busy        = busy_q;
   assign done        = done_q;

`ifdef CCFF_READBACK_EN
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         rb_cnt_q   <= '0;
         rb_acc_q   <= '0;
         rb_nb_q    <= '0;
         rb_data_q  <= '0;
         rb_valid_q <= 1'b0;
      end else begin
         rb_cnt_q   <= rb_cnt_d;
         rb_acc_q   <= rb_acc_d;
         rb_nb_q    <= rb_nb_d;
         rb_data_q  <= rb_data_d;
         rb_valid_q <= rb_valid_d;
      end
   end

   // During readback the tail is looped straight back to the head
   assign ccff_head = (state_q == RB) ? ccff_tail : head_q;
   assign rb_data   = rb_data_q;
   assign rb_valid  = rb_valid_q;
`else
   logic unused_rb;
   assign unused_rb = rb_req ^ ccff_tail;
   assign ccff_head = head_q;
   assign rb_data   = '0;
   assign rb_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Scoreboard bench for ccff_loader with a behavioural configuration chain.
module tb_ccff_loader;

   localparam int unsigned CL = 36;
   localparam int unsigned W  = 8;
   localparam int unsigned NW = 5;

   logic          prog_clk = 1'b0;
   logic          pReset, start, bs_valid, rb_req;
   logic [W-1:0]  bs_data;
   logic          bs_ready, ccff_head, ccff_tail, prog_clk_en, busy, done, rb_valid;
   logic [W-1:0]  rb_data;
   logic [CL-1:0] chain = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int shifts_seen = 0;

   bit           exp_bits[$];
   int           exp_done[$];
   logic [W-1:0] exp_rb[$];

   logic [W-1:0]  tw [NW];
   int            tg [NW];
   logic [CL-1:0] loaded_vec = '0;

   bit           mon_b;
   int           mon_d;
   logic [W-1:0] mon_w;

   ccff_loader #(.CHAIN_LEN(CL), .WORD_W(W)) dut (
      .prog_clk(prog_clk), .pReset(pReset), .start(start),
      .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
      .ccff_head(ccff_head), .ccff_tail(ccff_tail), .prog_clk_en(prog_clk_en),
      .busy(busy), .done(done), .rb_req(rb_req), .rb_data(rb_data), .rb_valid(rb_valid)
   );

   always #5 prog_clk = ~prog_clk;
   always @(posedge prog_clk) cyc <= cyc + 1;

   // Gated configuration chain: head enters bit 0, tail leaves bit CL-1
   always @(posedge prog_clk) if (prog_clk_en) chain <= {chain[CL-2:0], ccff_head};
   assign ccff_tail = chain[CL-1];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge prog_clk);
      #1;
   endtask

   // Monitor: pops expectations whenever the DUT presents something
   always @(negedge prog_clk) begin
      if (!pReset) begin
         if (prog_clk_en) begin
            if (exp_bits.size() == 0) chk("unexpected_shift", prog_clk_en, 1'b0);
            else begin
               mon_b = exp_bits.pop_front();
               chk("head_bit", ccff_head, mon_b);
               shifts_seen++;
            end
         end
         if (done) begin
            if (exp_done.size() == 0) chk("unexpected_done", done, 1'b0);
            else begin
               mon_d = exp_done.pop_front();
               chk("done_cycle", cyc, mon_d);
               chk("shift_count_left", exp_bits.size(), 0);
            end
         end
         if (rb_valid) begin
            if (exp_rb.size() == 0) chk("unexpected_rb_valid", rb_valid, 1'b0);
            else begin
               mon_w = exp_rb.pop_front();
               chk("rb_word", rb_data, mon_w);
            end
         end
      end
   end

   task automatic do_load(input bit poke, input int abort_after);
      int s, g, tmo, total, sh0, idx;
      bit acc, abort, tout;
      logic [CL-1:0] vec;
      total = 0; abort = 0; tout = 0; vec = '0;
      for (int k = 0; k < NW; k++) begin
         total += tg[k];
         for (int b = 0; b < W; b++) begin
            idx = k * W + b;
            if (idx < CL) begin
               exp_bits.push_back(tw[k][W-1-b]);
               vec[CL-1-idx] = tw[k][W-1-b];
            end
         end
      end
      sh0 = shifts_seen;
      start = 1'b1;
      s = cyc;
      exp_done.push_back(s + CL + 2 + total);
      tick();
      start = 1'b0;
      for (int k = 0; k < NW && !abort && !tout; k++) begin
         g = tg[k]; acc = 0; tmo = 0;
         while (!acc && !abort && !tout) begin
            if (abort_after >= 0 && shifts_seen - sh0 >= abort_after) begin
               abort = 1;
               break;
            end
            if (g > 0) begin
               bs_valid = 1'b0;
               if (bs_ready) g--;
            end else begin
               bs_valid = 1'b1;
               bs_data  = tw[k];
               acc      = bs_ready;
            end
            start = poke && (cyc == s + 10);
            if (poke && cyc == s + 10) chk("busy_during_load", busy, 1'b1);
            tick();
            tmo++;
            if (tmo > 200) begin
               chk("accept_timeout", bs_ready, 1'b1);
               tout = 1;
            end
         end
      end
      bs_valid = 1'b0;
      start    = 1'b0;
      tmo = 0;
      while (exp_done.size() != 0 && !abort && !tout) begin
         if (abort_after >= 0 && shifts_seen - sh0 >= abort_after) begin
            abort = 1;
            break;
         end
         tick();
         tmo++;
         if (tmo > 200) begin
            chk("done_timeout", done, 1'b1);
            tout = 1;
         end
      end
      if (abort) begin
         @(posedge prog_clk);
         #1 pReset = 1'b1;
         #1 chk("reset_outputs_midload",
                {bs_ready, ccff_head, prog_clk_en, busy, done, rb_valid, rb_data}, '0);
         exp_bits.delete();
         exp_done.delete();
         repeat (3) tick();
         pReset = 1'b0;
         repeat (4) tick();
         chk("busy_after_abort", busy, 1'b0);
      end else if (tout) begin
         exp_bits.delete();
         exp_done.delete();
      end else begin
         chk("chain_contents", 64'(chain), 64'(vec));
         loaded_vec = vec;
      end
      tick();
   endtask

`ifdef CCFF_READBACK_EN
   task automatic do_readback();
      int s, tmo, idx;
      logic [W-1:0] wd;
      for (int i = 0; i < CL; i++) exp_bits.push_back(loaded_vec[CL-1-i]);
      for (int k = 0; k < NW; k++) begin
         wd = '0;
         for (int b = 0; b < W; b++) begin
            idx = k * W + b;
            if (idx < CL) wd[W-1-b] = loaded_vec[CL-1-idx];
         end
         exp_rb.push_back(wd);
      end
      rb_req = 1'b1;
      s = cyc;
      exp_done.push_back(s + CL + 1);
      tick();
      rb_req = 1'b0;
      tmo = 0;
      while (exp_done.size() != 0 && tmo <= 200) begin
         tick();
         tmo++;
      end
      if (tmo > 200) chk("rb_timeout", done, 1'b1);
      chk("rb_queue_drained", exp_rb.size(), 0);
      chk("chain_after_rb", 64'(chain), 64'(loaded_vec));
      tick();
   endtask
`endif

   task automatic set_directed();
      tw[0] = 8'hA5; tw[1] = 8'h3C; tw[2] = 8'h0F; tw[3] = 8'hF0; tw[4] = 8'h90;
      for (int k = 0; k < NW; k++) tg[k] = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      pReset = 1'b1; start = 1'b0; bs_valid = 1'b0; bs_data = '0; rb_req = 1'b0;
      #1 chk("reset_outputs", {bs_ready, ccff_head, prog_clk_en, busy, done, rb_valid, rb_data}, '0);
      repeat (3) tick();
      pReset = 1'b0;
      tick();

      // Continuous load of the reference words
      set_directed();
      do_load(1'b0, -1);

      // Three-cycle stall before word 3
      set_directed();
      tg[3] = 3;
      do_load(1'b0, -1);

`ifdef CCFF_READBACK_EN
      do_readback();
      do_readback();
`endif

      // Garbage valid (and readback request when not built in) while idle
      for (int i = 0; i < 6; i++) begin
         bs_valid = 1'b1;
         bs_data  = W'($urandom);
`ifndef CCFF_READBACK_EN
         rb_req = 1'b1;
`endif
         tick();
         chk("ready_idle", bs_ready, 1'b0);
         chk("busy_idle", busy, 1'b0);
         chk("clk_en_idle", prog_clk_en, 1'b0);
         chk("rb_valid_idle", rb_valid, 1'b0);
      end
      bs_valid = 1'b0;
      rb_req   = 1'b0;
      tick();

      // Start pulse while busy must be ignored
      set_directed();
      do_load(1'b1, -1);

      // Reset after 17 shifts, then a clean load
      set_directed();
      do_load(1'b0, 17);
      set_directed();
      do_load(1'b0, -1);

      // Randomised words and stalls
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < NW; k++) begin
            tw[k] = W'($urandom);
            tg[k] = int'($urandom_range(0, 3));
         end
         do_load(1'b0, -1);
`ifdef CCFF_READBACK_EN
         do_readback();
`endif
      end

      repeat (5) tick();
      chk("final_exp_bits_empty", exp_bits.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
